// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared types and default widths for the mem_resp block
package mem_pkg;

    localparam int DEF_ADDR_W = 8;
    localparam int DEF_DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef enum logic {
        OP_RD = 1'b0,
        OP_WR = 1'b1
    } op_t;

endpackage

// File: rtl/mem_resp_array.sv
// rtl/mem_resp_array.sv - single-port storage, synchronous write, registered read, no reset
module mem_resp_array #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/mem_resp.sv
// rtl/mem_resp.sv - wait-state memory responder; MEM_RESP_STATS_EN adds wr_cnt/rd_cnt
module mem_resp
    import mem_pkg::*;
#(
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int DATA_W      = DEF_DATA_W,
    parameter int WAIT_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cs,
    input  logic              we,
    input  logic              re,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out,
    output logic              ack,
    output logic              err
`ifdef MEM_RESP_STATS_EN
    ,
    output logic [15:0]       wr_cnt,
    output logic [15:0]       rd_cnt
`endif
);

    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

    state_t            state;
    op_t               op_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] data_q;
    logic [3:0]        wait_cnt;
    logic [DATA_W-1:0] rd_data;
    logic [ADDR_W-1:0] arr_addr;
    logic              arr_we;
    logic              req_ok;
    logic              req_bad;

    assign req_ok  = cs && (we ^ re);
    assign req_bad = cs && we && re;

    // In IDLE the array already looks up the incoming address, so read data
    // is ready by DONE even with zero wait states.
    assign arr_addr = (state == IDLE) ? addr : addr_q;
    assign arr_we   = (state == DONE) && (op_q == OP_WR);

    mem_resp_array #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_array (
        .clk   (clk),
        .we    (arr_we),
        .addr  (arr_addr),
        .wdata (data_q),
        .rdata (rd_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            op_q     <= OP_RD;
            addr_q   <= '0;
            data_q   <= '0;
            wait_cnt <= '0;
            data_out <= '0;
            ack      <= 1'b0;
            err      <= 1'b0;
        end else begin
            ack <= 1'b0;
            err <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_ok) begin
                        op_q     <= we ? OP_WR : OP_RD;
                        addr_q   <= addr;
                        data_q   <= data_in;
                        wait_cnt <= WAIT_INIT;
                        state    <= (WAIT_INIT != 4'd0) ? WAIT : DONE;
                    end else if (req_bad) begin
                        err <= 1'b1;
                    end
                end
                WAIT: begin
                    if (wait_cnt <= 4'd1) begin
                        wait_cnt <= 4'd0;
                        state    <= DONE;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                DONE: begin
                    ack <= 1'b1;
                    if (op_q == OP_RD) begin
                        data_out <= rd_data;
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef MEM_RESP_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_cnt <= '0;
            rd_cnt <= '0;
        end else if (state == DONE) begin
            if (op_q == OP_WR && wr_cnt != 16'hFFFF) begin
                wr_cnt <= wr_cnt + 16'd1;
            end
            if (op_q == OP_RD && rd_cnt != 16'hFFFF) begin
                rd_cnt <= rd_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_mem_resp.sv
// tb/tb_mem_resp.sv - directed self-checking bench for mem_resp (one and zero wait states)
module tb_mem_resp;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cs, we, re;
    logic [7:0] addr, data_in, data_out;
    logic       ack, err;
    logic       cs0, we0, re0;
    logic [7:0] addr0, data_in0, data_out0;
    logic       ack0, err0;
`ifdef MEM_RESP_STATS_EN
    logic [15:0] wr_cnt, rd_cnt, wr_cnt0, rd_cnt0;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_resp #(.ADDR_W(8), .DATA_W(8), .WAIT_CYCLES(1)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .cs       (cs),
        .we       (we),
        .re       (re),
        .addr     (addr),
        .data_in  (data_in),
        .data_out (data_out),
        .ack      (ack),
        .err      (err)
`ifdef MEM_RESP_STATS_EN
        ,
        .wr_cnt   (wr_cnt),
        .rd_cnt   (rd_cnt)
`endif
    );

    mem_resp #(.ADDR_W(8), .DATA_W(8), .WAIT_CYCLES(0)) dut0 (
        .clk      (clk),
        .rst_n    (rst_n),
        .cs       (cs0),
        .we       (we0),
        .re       (re0),
        .addr     (addr0),
        .data_in  (data_in0),
        .data_out (data_out0),
        .ack      (ack0),
        .err      (err0)
`ifdef MEM_RESP_STATS_EN
        ,
        .wr_cnt   (wr_cnt0),
        .rd_cnt   (rd_cnt0)
`endif
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Request goes in before posedge N; ack must appear only after posedge N+2.
    task automatic acc(input logic wr, input logic [7:0] a, input logic [7:0] d,
                       input logic [7:0] exp, input string tag);
        @(negedge clk);
        cs = 1'b1; we = wr; re = ~wr; addr = a; data_in = d;
        @(negedge clk);
        cs = 1'b0; we = 1'b0; re = 1'b0;
        @(negedge clk);
        chk({tag, "_ack_early"}, {15'd0, ack}, 16'd0);
        @(negedge clk);
        chk({tag, "_ack"}, {15'd0, ack}, 16'd1);
        if (!wr) chk({tag, "_data"}, {8'd0, data_out}, {8'd0, exp});
        @(negedge clk);
        chk({tag, "_ack_clr"}, {15'd0, ack}, 16'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        cs = 0; we = 0; re = 0; addr = 0; data_in = 0;
        cs0 = 0; we0 = 0; re0 = 0; addr0 = 0; data_in0 = 0;
        #12;
        chk("rst_data_out", {8'd0, data_out}, 16'd0);
        chk("rst_ack", {15'd0, ack}, 16'd0);
        chk("rst_err", {15'd0, err}, 16'd0);
        @(negedge clk);
        rst_n = 1'b1;

        acc(1'b1, 8'd0, 8'hFF, 8'h00, "wr0");
        acc(1'b1, 8'd1, 8'hAA, 8'h00, "wr1");
        acc(1'b1, 8'd2, 8'hBB, 8'h00, "wr2");
        acc(1'b0, 8'd0, 8'h00, 8'hFF, "rd0");
        acc(1'b0, 8'd1, 8'h00, 8'hAA, "rd1");
        acc(1'b0, 8'd2, 8'h00, 8'hBB, "rd2");
`ifdef MEM_RESP_STATS_EN
        chk("wr_cnt_3", wr_cnt, 16'd3);
        chk("rd_cnt_3", rd_cnt, 16'd3);
`endif

        // Illegal command: both strobes high.
        @(negedge clk);
        cs = 1'b1; we = 1'b1; re = 1'b1; addr = 8'd0;
        @(negedge clk);
        cs = 1'b0; we = 1'b0; re = 1'b0;
        chk("ill_err", {15'd0, err}, 16'd1);
        chk("ill_ack", {15'd0, ack}, 16'd0);
        @(negedge clk);
        chk("ill_err_clr", {15'd0, err}, 16'd0);
        chk("ill_ack_late", {15'd0, ack}, 16'd0);
        @(negedge clk);
        chk("ill_ack_late2", {15'd0, ack}, 16'd0);
`ifdef MEM_RESP_STATS_EN
        chk("ill_wr_cnt", wr_cnt, 16'd3);
        chk("ill_rd_cnt", rd_cnt, 16'd3);
`endif
        acc(1'b0, 8'd0, 8'h00, 8'hFF, "rd0_after_ill");

        // Inputs changed (and an illegal command offered) during WAIT are ignored.
        acc(1'b1, 8'd4, 8'h44, 8'h00, "wr4");
        @(negedge clk);
        cs = 1'b1; we = 1'b1; re = 1'b0; addr = 8'd3; data_in = 8'h55;
        @(negedge clk);
        re = 1'b1; addr = 8'd4; data_in = 8'h00;
        @(negedge clk);
        chk("chg_err", {15'd0, err}, 16'd0);
        cs = 1'b0; we = 1'b0; re = 1'b0;
        @(negedge clk);
        chk("chg_ack", {15'd0, ack}, 16'd1);
        chk("chg_err2", {15'd0, err}, 16'd0);
        acc(1'b0, 8'd3, 8'h00, 8'h55, "rd3");
        acc(1'b0, 8'd4, 8'h00, 8'h44, "rd4");

        // Reset during WAIT aborts the write.
        acc(1'b1, 8'd5, 8'h77, 8'h00, "wr5");
        acc(1'b0, 8'd5, 8'h00, 8'h77, "rd5_pre");
        @(negedge clk);
        cs = 1'b1; we = 1'b1; re = 1'b0; addr = 8'd5; data_in = 8'h11;
        @(negedge clk);
        cs = 1'b0; we = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("abort_data_out", {8'd0, data_out}, 16'd0);
        chk("abort_ack", {15'd0, ack}, 16'd0);
        chk("abort_err", {15'd0, err}, 16'd0);
`ifdef MEM_RESP_STATS_EN
        chk("abort_wr_cnt", wr_cnt, 16'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("abort_no_ack", {15'd0, ack}, 16'd0);
        end
        acc(1'b0, 8'd5, 8'h00, 8'h77, "rd5_post");

        // Zero wait states: ack after the second edge.
        @(negedge clk);
        cs0 = 1'b1; we0 = 1'b1; re0 = 1'b0; addr0 = 8'd7; data_in0 = 8'h3C;
        @(negedge clk);
        cs0 = 1'b0; we0 = 1'b0;
        chk("w0_wr_ack_early", {15'd0, ack0}, 16'd0);
        @(negedge clk);
        chk("w0_wr_ack", {15'd0, ack0}, 16'd1);
        @(negedge clk);
        chk("w0_wr_ack_clr", {15'd0, ack0}, 16'd0);
        cs0 = 1'b1; re0 = 1'b1; addr0 = 8'd7; data_in0 = 8'h00;
        @(negedge clk);
        cs0 = 1'b0; re0 = 1'b0;
        chk("w0_rd_ack_early", {15'd0, ack0}, 16'd0);
        @(negedge clk);
        chk("w0_rd_ack", {15'd0, ack0}, 16'd1);
        chk("w0_rd_data", {8'd0, data_out0}, 16'h003C);
        @(negedge clk);
        chk("w0_rd_ack_clr", {15'd0, ack0}, 16'd0);
`ifdef MEM_RESP_STATS_EN
        chk("w0_wr_cnt", wr_cnt0, 16'd1);
        chk("w0_rd_cnt", rd_cnt0, 16'd1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
